// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor D = A - B, LSB first, with start/busy/done handshake.
// Optional signed overflow flag enabled by defining SUBTRATOR_SERIAL_OVERFLOW_EN.
module subtrator_serial #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inicio,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         ovf,
  output logic         ocupado,
  output logic         pronto
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          br_q, br_d;
  logic          bout_q, bout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic x, y, diff, br_nx, start, last;

  assign x     = a_q[0];
  assign y     = b_q[0];
  assign diff  = x ^ y ^ br_q;
  assign br_nx = (~x & y) | (~(x ^ y) & br_q);
  assign start = (state_q == IDLE) && inicio;
  assign last  = (state_q == RUN) && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          r_d     = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {diff, r_q[N-1:1]};
        br_d  = br_nx;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          // Result is published from the shift value being formed this cycle.
          state_d = DONE;
          d_d     = {diff, r_q[N-1:1]};
          bout_d  = br_nx;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef SUBTRATOR_SERIAL_OVERFLOW_EN
  logic sa_q, sa_d;
  logic sb_q, sb_d;
  logic ovf_q, ovf_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      sa_q  <= sa_d;
      sb_q  <= sb_d;
      ovf_q <= ovf_d;
    end
  end

  always_comb begin
    sa_d  = sa_q;
    sb_d  = sb_q;
    ovf_d = ovf_q;
    if (start) begin
      sa_d = a[N-1];
      sb_d = b[N-1];
    end
    // diff on the last RUN cycle is the result sign bit.
    if (last) ovf_d = (sa_q != sb_q) && (diff != sa_q);
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign d       = d_q;
  assign bout    = bout_q;
  assign ocupado = busy_q;
  assign pronto  = done_q;

endmodule
